// File: rtl/temporizador_rega_pkg.sv
// Shared types and helpers for the irrigation countdown timer.
// Holds the sequencer states, digit limits and the preset clamp.
package temporizador_rega_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } estado_t;

  localparam int unsigned MAX_BCD  = 9;
  localparam int unsigned MAX_DSEC = 5;

  // Saturate a preset digit to its limit.
  function automatic logic [3:0] clamp(input logic [3:0] valor, input logic [3:0] limite);
    return (valor > limite) ? limite : valor;
  endfunction

endpackage

// File: rtl/digito_regressivo.sv
// One down-counting digit of the M:SS chain.
// The digit wraps 0 -> MAX and raises borrow_out for the next digit up.
module digito_regressivo #(
  parameter int unsigned MAX   = 9,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             Pulso,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] valor,
  output logic             borrow_out
);

  assign borrow_out = en && (valor == '0);

  always_ff @(posedge clock or negedge Pulso) begin
    if (!Pulso) begin
      valor <= '0;
    end else if (clear) begin
      valor <= '0;
    end else if (load) begin
      valor <= load_val;
    end else if (en) begin
      valor <= (valor == '0) ? WIDTH'(MAX) : valor - WIDTH'(1);
    end
  end

endmodule

// File: rtl/temporizador_rega.sv
// Irrigation countdown sequencer: loads an M:SS preset, holds the valve open
// while counting down one second per tick, then pulses fim at 0:00.
module temporizador_rega
  import temporizador_rega_pkg::*;
#(
  parameter int unsigned MAX_MIN = 9
) (
  input  logic       clock,
  input  logic       Pulso,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] preset_min,
  input  logic [2:0] preset_dsec,
  input  logic [3:0] preset_usec,
  output logic [3:0] QMinutos,
  output logic [2:0] QDSegundos,
  output logic [3:0] QUSegundos,
  output logic       valvula,
  output logic       ocupado,
  output logic       fim
);

  localparam logic [3:0] MinLim  = 4'(MAX_MIN);
  localparam logic [3:0] UsecLim = 4'(MAX_BCD);
  localparam logic [3:0] DsecLim = 4'(MAX_DSEC);

  estado_t    estado;
  logic [3:0] load_min;
  logic [3:0] load_usec;
  logic [3:0] load_dsec_w;
  logic [2:0] load_dsec;
  logic       load_zero;
  logic       last_tick;
  logic       load;
  logic       clear;
  logic       en_usec;
  logic       borrow_usec;
  logic       borrow_dsec;
  logic       borrow_min;

  always_comb begin
    load_usec   = clamp(preset_usec, UsecLim);
    load_dsec_w = clamp({1'b0, preset_dsec}, DsecLim);
    load_dsec   = load_dsec_w[2:0];
    load_min    = clamp(preset_min, MinLim);
  end

  assign load_zero = (load_min == 4'd0) && (load_dsec == 3'd0) && (load_usec == 4'd0);
  assign last_tick = (QMinutos == 4'd0) && (QDSegundos == 3'd0) && (QUSegundos == 4'd1);

  assign load    = (estado == IDLE) && start && !stop;
  assign en_usec = (estado == RUN) && tick_1hz && !stop;
  // A borrow out of the minutes would mean a tick at 0:00; clear instead of wrapping.
  assign clear   = ((estado == RUN) && stop) || borrow_min;

  digito_regressivo #(
    .MAX  (MAX_BCD),
    .WIDTH(4)
  ) u_usec (
    .clock     (clock),
    .Pulso     (Pulso),
    .load      (load),
    .load_val  (load_usec),
    .clear     (clear),
    .en        (en_usec),
    .valor     (QUSegundos),
    .borrow_out(borrow_usec)
  );

  digito_regressivo #(
    .MAX  (MAX_DSEC),
    .WIDTH(3)
  ) u_dsec (
    .clock     (clock),
    .Pulso     (Pulso),
    .load      (load),
    .load_val  (load_dsec),
    .clear     (clear),
    .en        (borrow_usec),
    .valor     (QDSegundos),
    .borrow_out(borrow_dsec)
  );

  digito_regressivo #(
    .MAX  (MAX_MIN),
    .WIDTH(4)
  ) u_min (
    .clock     (clock),
    .Pulso     (Pulso),
    .load      (load),
    .load_val  (load_min),
    .clear     (clear),
    .en        (borrow_dsec),
    .valor     (QMinutos),
    .borrow_out(borrow_min)
  );

  always_ff @(posedge clock or negedge Pulso) begin
    if (!Pulso) begin
      estado  <= IDLE;
      valvula <= 1'b0;
      ocupado <= 1'b0;
      fim     <= 1'b0;
    end else begin
      fim <= 1'b0;
      unique case (estado)
        IDLE: begin
          if (load) begin
            if (load_zero) begin
              estado <= DONE;
              fim    <= 1'b1;
            end else begin
              estado  <= RUN;
              valvula <= 1'b1;
              ocupado <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            estado  <= IDLE;
            valvula <= 1'b0;
            ocupado <= 1'b0;
          end else if (tick_1hz && (last_tick || borrow_min)) begin
            estado  <= DONE;
            valvula <= 1'b0;
            ocupado <= 1'b0;
            fim     <= 1'b1;
          end
        end
        DONE: begin
          estado <= IDLE;
        end
        default: begin
          estado  <= IDLE;
          valvula <= 1'b0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temporizador_rega.sv
// Bench for temporizador_rega: directed table, corner sequences and random
// stimulus checked against a seconds-based reference model.
module tb_temporizador_rega;

  localparam int MaxMin = 9;

  logic       clock = 1'b0;
  logic       Pulso;
  logic       tick_1hz, start, stop;
  logic [3:0] preset_min, preset_usec;
  logic [2:0] preset_dsec;
  logic [3:0] QMinutos, QUSegundos;
  logic [2:0] QDSegundos;
  logic       valvula, ocupado, fim;

  temporizador_rega #(.MAX_MIN(MaxMin)) dut (
    .clock      (clock),
    .Pulso      (Pulso),
    .tick_1hz   (tick_1hz),
    .start      (start),
    .stop       (stop),
    .preset_min (preset_min),
    .preset_dsec(preset_dsec),
    .preset_usec(preset_usec),
    .QMinutos   (QMinutos),
    .QDSegundos (QDSegundos),
    .QUSegundos (QUSegundos),
    .valvula    (valvula),
    .ocupado    (ocupado),
    .fim        (fim)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: remaining time as plain seconds plus a coarse mode.
  int secs = 0;
  int mode = 0;  // 0 idle, 1 counting, 2 completion cycle

  typedef struct {
    logic       st, sp, tk;
    logic [3:0] pm;
    logic [2:0] pd;
    logic [3:0] pu;
    int         em, ed, eu, ev, ef;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lim(input int v, input int l);
    return (v > l) ? l : v;
  endfunction

  task automatic model_step(input logic st, input logic sp, input logic tk,
                            input int pm, input int pd, input int pu);
    case (mode)
      0: if (st && !sp) begin
        secs = lim(pm, MaxMin) * 60 + lim(pd, 5) * 10 + lim(pu, 9);
        mode = (secs == 0) ? 2 : 1;
      end
      1: if (sp) begin
        secs = 0;
        mode = 0;
      end else if (tk) begin
        secs = secs - 1;
        if (secs == 0) mode = 2;
      end
      default: mode = 0;
    endcase
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".min"}, int'(QMinutos), secs / 60);
    chk({tag, ".dsec"}, int'(QDSegundos), (secs % 60) / 10);
    chk({tag, ".usec"}, int'(QUSegundos), secs % 10);
    chk({tag, ".valvula"}, int'(valvula), int'(mode == 1));
    chk({tag, ".ocupado"}, int'(ocupado), int'(mode == 1));
    chk({tag, ".fim"}, int'(fim), int'(mode == 2));
  endtask

  task automatic step(input logic st, input logic sp, input logic tk,
                      input logic [3:0] pm, input logic [2:0] pd, input logic [3:0] pu,
                      input string tag);
    @(negedge clock);
    start = st; stop = sp; tick_1hz = tk;
    preset_min = pm; preset_dsec = pd; preset_usec = pu;
    @(posedge clock);
    model_step(st, sp, tk, int'(pm), int'(pd), int'(pu));
    #1;
    chk_model(tag);
  endtask

  task automatic idle_step(input string tag);
    step(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 4'd0, tag);
  endtask

  task automatic tick_step(input string tag);
    step(1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 4'd0, tag);
  endtask

  initial begin
    int valv_cycles, fim_cycles, fim_at;

    //          st    sp    tk    pm     pd    pu     em ed eu ev ef
    tv[0]  = '{1'b1, 1'b0, 1'b0, 4'd2,  3'd0, 4'd0,  2, 0, 0, 1, 0};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  1, 5, 9, 1, 0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 4'd0,  0, 0, 0, 0, 0};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 4'd15, 3'd7, 4'd12, 9, 5, 9, 1, 0};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 4'd1,  3'd1, 4'd1,  9, 5, 9, 1, 0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  9, 5, 8, 1, 0};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 4'd3,  3'd3, 4'd3,  0, 0, 0, 0, 0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 4'd0,  0, 0, 0, 0, 1};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 4'd0,  0, 0, 0, 0, 0};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  0, 0, 0, 0, 0};
    tv[10] = '{1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 4'd1,  0, 0, 1, 1, 0};
    tv[11] = '{1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  0, 0, 0, 0, 1};
    tv[12] = '{1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  0, 0, 0, 0, 0};

    Pulso = 1'b0;
    start = 1'b0; stop = 1'b0; tick_1hz = 1'b0;
    preset_min = 4'd0; preset_dsec = 3'd0; preset_usec = 4'd0;
    #3;
    chk("reset.digits", int'({QMinutos, QDSegundos, QUSegundos}), 0);
    chk("reset.flags", int'({valvula, ocupado, fim}), 0);
    repeat (2) @(negedge clock);
    Pulso = 1'b1;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      step(tv[i].st, tv[i].sp, tv[i].tk, tv[i].pm, tv[i].pd, tv[i].pu, $sformatf("vec%0d", i));
      chk($sformatf("tab%0d.min", i), int'(QMinutos), tv[i].em);
      chk($sformatf("tab%0d.dsec", i), int'(QDSegundos), tv[i].ed);
      chk($sformatf("tab%0d.usec", i), int'(QUSegundos), tv[i].eu);
      chk($sformatf("tab%0d.valv", i), int'(valvula), tv[i].ev);
      chk($sformatf("tab%0d.fim", i), int'(fim), tv[i].ef);
    end

    // 0:12 with a tick every fourth cycle: valve open for 12 tick intervals.
    valv_cycles = 0; fim_cycles = 0; fim_at = -1;
    step(1'b1, 1'b0, 1'b0, 4'd0, 3'd1, 4'd2, "s12.load");
    valv_cycles += int'(valvula);
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 3; k++) begin
        idle_step("s12.gap");
        valv_cycles += int'(valvula);
        fim_cycles  += int'(fim);
      end
      tick_step("s12.tick");
      chk("s12.secs", int'(QDSegundos) * 10 + int'(QUSegundos), 11 - t);
      valv_cycles += int'(valvula);
      fim_cycles  += int'(fim);
      if (fim) fim_at = t;
    end
    for (int k = 0; k < 3; k++) begin
      idle_step("s12.tail");
      fim_cycles += int'(fim);
    end
    chk("s12.valv_cycles", valv_cycles, 48);
    chk("s12.fim_count", fim_cycles, 1);
    chk("s12.fim_at", fim_at, 11);

    // 0:45, stop and tick together.
    step(1'b1, 1'b0, 1'b0, 4'd0, 3'd4, 4'd5, "s45.load");
    chk("s45.loaded", int'({QMinutos, 1'b0, QDSegundos, QUSegundos}), 'h045);
    step(1'b0, 1'b1, 1'b1, 4'd0, 3'd0, 4'd0, "s45.stop");
    chk("s45.cleared", int'({QMinutos, QDSegundos, QUSegundos, valvula, fim}), 0);

    // Reset in the middle of a 1:30 count.
    step(1'b1, 1'b0, 1'b0, 4'd1, 3'd3, 4'd0, "s130.load");
    tick_step("s130.tick");
    #2;
    Pulso = 1'b0;
    #1;
    chk("s130.async_digits", int'({QMinutos, QDSegundos, QUSegundos}), 0);
    chk("s130.async_flags", int'({valvula, ocupado, fim}), 0);
    secs = 0; mode = 0;
    @(negedge clock);
    Pulso = 1'b1;
    tick_step("s130.tick_after");
    tick_step("s130.tick_after2");
    chk("s130.no_count", int'({QMinutos, QDSegundos, QUSegundos, valvula}), 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic rs, rp, rt;
      rs = ($urandom_range(0, 3) == 0);
      rp = ($urandom_range(0, 40) == 0);
      rt = ($urandom_range(0, 1) == 1);
      step(rs, rp, rt, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
